// File: rtl/axis_reduce_pkg.sv
// Shared types and constants for the AXI4-Stream packet reducer.
// Result words leave in the order count, sum, min, max.
package axis_reduce_pkg;

    typedef enum logic {
        ACCUM = 1'b0,
        EMIT  = 1'b1
    } state_t;

    localparam logic [1:0] WORD_CNT  = 2'd0;
    localparam logic [1:0] WORD_SUM  = 2'd1;
    localparam logic [1:0] WORD_MIN  = 2'd2;
    localparam logic [1:0] WORD_MAX  = 2'd3;
    localparam logic [1:0] WORD_LAST = 2'd3;

    localparam logic [31:0] MIN_INIT = '1;

endpackage

// File: rtl/axis_reduce_acc.sv
// Per-packet accumulators: byte-strobe masking and the count/sum/min/max registers.
// The beat_* outputs include the current beat, so a TLAST beat can be latched directly.
module axis_reduce_acc
    import axis_reduce_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int CNT_W  = 16
) (
    input  logic                  CLK,
    input  logic                  RST_N,
    input  logic                  clear,
    input  logic                  update,
    input  logic [DATA_W-1:0]     data,
    input  logic [DATA_W/8-1:0]   strb,
    output logic [CNT_W-1:0]      beat_count,
    output logic [DATA_W-1:0]     beat_sum,
    output logic [DATA_W-1:0]     beat_min,
    output logic [DATA_W-1:0]     beat_max
);

    localparam logic [DATA_W-1:0] MinReset = DATA_W'(MIN_INIT);

    logic [DATA_W-1:0] masked;
    logic              beat_live;
    logic [CNT_W-1:0]  count_q, count_next;
    logic [DATA_W-1:0] sum_q, sum_next;
    logic [DATA_W-1:0] min_q, min_next;
    logic [DATA_W-1:0] max_q, max_next;

    always_comb begin
        masked = '0;
        for (int b = 0; b < DATA_W/8; b++) begin
            masked[b*8 +: 8] = strb[b] ? data[b*8 +: 8] : 8'h00;
        end
    end

    // A beat with no strobes set carries no data and leaves the statistics untouched.
    assign beat_live  = update && (strb != '0);
    assign count_next = (count_q == '1) ? count_q : count_q + CNT_W'(1);
    assign sum_next   = sum_q + masked;
    assign min_next   = (masked < min_q) ? masked : min_q;
    assign max_next   = (masked > max_q) ? masked : max_q;

    assign beat_count = beat_live ? count_next : count_q;
    assign beat_sum   = beat_live ? sum_next   : sum_q;
    assign beat_min   = beat_live ? min_next   : min_q;
    assign beat_max   = beat_live ? max_next   : max_q;

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            count_q <= '0;
            sum_q   <= '0;
            min_q   <= MinReset;
            max_q   <= '0;
        end else if (clear) begin
            count_q <= '0;
            sum_q   <= '0;
            min_q   <= MinReset;
            max_q   <= '0;
        end else if (beat_live) begin
            count_q <= count_next;
            sum_q   <= sum_next;
            min_q   <= min_next;
            max_q   <= max_next;
        end
    end

endmodule

// File: rtl/axis_stream_reduce.sv
// AXI4-Stream slave reducing each TLAST-delimited packet to a 4-word result packet
// (count, sum, min, max); input is stalled while the result is being emitted.
module axis_stream_reduce
    import axis_reduce_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int CNT_W  = 16
) (
    input  logic                  CLK,
    input  logic                  RST_N,
    input  logic [DATA_W-1:0]     S_AXIS_TDATA,
    input  logic [DATA_W/8-1:0]   S_AXIS_TSTRB,
    input  logic                  S_AXIS_TKEEP,
    input  logic                  S_AXIS_TLAST,
    input  logic                  S_AXIS_TVALID,
    output logic                  S_AXIS_TREADY,
    output logic [DATA_W-1:0]     M_AXIS_TDATA,
    output logic [DATA_W/8-1:0]   M_AXIS_TSTRB,
    output logic                  M_AXIS_TLAST,
    output logic                  M_AXIS_TVALID,
    input  logic                  M_AXIS_TREADY
);

    state_t            state_q, state_d;
    logic [1:0]        word_idx_q, word_idx_d;
    logic              s_ready_q;
    logic              in_fire, last_fire, out_fire;
    logic [CNT_W-1:0]  beat_count, res_count;
    logic [DATA_W-1:0] beat_sum, beat_min, beat_max;
    logic [DATA_W-1:0] res_sum, res_min, res_max;
    logic              unused_keep;

    assign unused_keep = S_AXIS_TKEEP;

    assign in_fire   = S_AXIS_TVALID && s_ready_q;
    assign last_fire = in_fire && S_AXIS_TLAST;
    assign out_fire  = (state_q == EMIT) && M_AXIS_TREADY;

    axis_reduce_acc #(
        .DATA_W (DATA_W),
        .CNT_W  (CNT_W)
    ) u_acc (
        .CLK        (CLK),
        .RST_N      (RST_N),
        .clear      (last_fire),
        .update     (in_fire),
        .data       (S_AXIS_TDATA),
        .strb       (S_AXIS_TSTRB),
        .beat_count (beat_count),
        .beat_sum   (beat_sum),
        .beat_min   (beat_min),
        .beat_max   (beat_max)
    );

    // Ready is registered so it stays low through reset and rises one edge after release.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_q    <= ACCUM;
            word_idx_q <= WORD_CNT;
            s_ready_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            word_idx_q <= word_idx_d;
            s_ready_q  <= (state_d == ACCUM);
        end
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            res_count <= '0;
            res_sum   <= '0;
            res_min   <= '0;
            res_max   <= '0;
        end else if (last_fire) begin
            res_count <= beat_count;
            res_sum   <= beat_sum;
            res_min   <= beat_min;
            res_max   <= beat_max;
        end
    end

    always_comb begin
        state_d    = state_q;
        word_idx_d = word_idx_q;
        case (state_q)
            ACCUM: begin
                if (last_fire) begin
                    state_d    = EMIT;
                    word_idx_d = WORD_CNT;
                end
            end
            EMIT: begin
                if (out_fire) begin
                    if (word_idx_q == WORD_LAST) begin
                        state_d    = ACCUM;
                        word_idx_d = WORD_CNT;
                    end else begin
                        word_idx_d = word_idx_q + 2'd1;
                    end
                end
            end
            default: begin
                state_d    = ACCUM;
                word_idx_d = WORD_CNT;
            end
        endcase
    end

    always_comb begin
        S_AXIS_TREADY = s_ready_q;
        M_AXIS_TVALID = 1'b0;
        M_AXIS_TSTRB  = '0;
        M_AXIS_TLAST  = 1'b0;
        M_AXIS_TDATA  = '0;
        if (state_q == EMIT) begin
            M_AXIS_TVALID = 1'b1;
            M_AXIS_TSTRB  = '1;
            M_AXIS_TLAST  = (word_idx_q == WORD_LAST);
            case (word_idx_q)
                WORD_CNT: M_AXIS_TDATA = DATA_W'(res_count);
                WORD_SUM: M_AXIS_TDATA = res_sum;
                WORD_MIN: M_AXIS_TDATA = res_min;
                WORD_MAX: M_AXIS_TDATA = res_max;
                default:  M_AXIS_TDATA = '0;
            endcase
        end
    end

endmodule

// File: tb/tb_axis_stream_reduce.sv
// Directed self-checking bench for axis_stream_reduce with hand-computed result packets.
module tb_axis_stream_reduce;

    localparam int DATA_W = 32;
    localparam int CNT_W  = 16;

    logic                CLK = 1'b0;
    logic                RST_N;
    logic [DATA_W-1:0]   S_AXIS_TDATA;
    logic [DATA_W/8-1:0] S_AXIS_TSTRB;
    logic                S_AXIS_TKEEP;
    logic                S_AXIS_TLAST;
    logic                S_AXIS_TVALID;
    logic                S_AXIS_TREADY;
    logic [DATA_W-1:0]   M_AXIS_TDATA;
    logic [DATA_W/8-1:0] M_AXIS_TSTRB;
    logic                M_AXIS_TLAST;
    logic                M_AXIS_TVALID;
    logic                M_AXIS_TREADY;

    int checkCount = 0;
    int passCount  = 0;

    axis_stream_reduce #(
        .DATA_W (DATA_W),
        .CNT_W  (CNT_W)
    ) dut (
        .CLK           (CLK),
        .RST_N         (RST_N),
        .S_AXIS_TDATA  (S_AXIS_TDATA),
        .S_AXIS_TSTRB  (S_AXIS_TSTRB),
        .S_AXIS_TKEEP  (S_AXIS_TKEEP),
        .S_AXIS_TLAST  (S_AXIS_TLAST),
        .S_AXIS_TVALID (S_AXIS_TVALID),
        .S_AXIS_TREADY (S_AXIS_TREADY),
        .M_AXIS_TDATA  (M_AXIS_TDATA),
        .M_AXIS_TSTRB  (M_AXIS_TSTRB),
        .M_AXIS_TLAST  (M_AXIS_TLAST),
        .M_AXIS_TVALID (M_AXIS_TVALID),
        .M_AXIS_TREADY (M_AXIS_TREADY)
    );

    always #5 CLK = ~CLK;

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        checkCount++;
        if (actual === expected) passCount++;
        else $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", tag, actual, expected);
    endtask

    // Drives one beat and holds it until the DUT takes it; returns cycles spent waiting on ready.
    task automatic applyStimulus(input logic [31:0] data, input logic [3:0] strb, input logic last,
                                 output int waitCycles);
        bit accepted;
        accepted      = 1'b0;
        waitCycles    = 0;
        S_AXIS_TDATA  = data;
        S_AXIS_TSTRB  = strb;
        S_AXIS_TLAST  = last;
        S_AXIS_TKEEP  = 1'($urandom_range(0, 1));
        S_AXIS_TVALID = 1'b1;
        while (!accepted && waitCycles < 50) begin
            @(negedge CLK);
            if (S_AXIS_TREADY) accepted = 1'b1;
            else waitCycles++;
        end
        checkOutput("beat_accepted", 32'(accepted), 32'd1);
        @(posedge CLK);
        #1;
        S_AXIS_TVALID = 1'b0;
        S_AXIS_TLAST  = 1'b0;
    endtask

    task automatic collectWord(input string tag, input logic [31:0] expData, input logic expLast);
        bit found;
        int n;
        found = 1'b0;
        n     = 0;
        while (!found && n < 50) begin
            @(negedge CLK);
            if (M_AXIS_TVALID && M_AXIS_TREADY) found = 1'b1;
            else n++;
        end
        checkOutput({tag, "_valid"}, 32'(found), 32'd1);
        checkOutput({tag, "_data"}, M_AXIS_TDATA, expData);
        checkOutput({tag, "_last"}, 32'(M_AXIS_TLAST), 32'(expLast));
        checkOutput({tag, "_strb"}, 32'(M_AXIS_TSTRB), 32'h0000000F);
        @(posedge CLK);
        #1;
    endtask

    task automatic collectResult(input string tag, input logic [31:0] c, input logic [31:0] s,
                                 input logic [31:0] mn, input logic [31:0] mx);
        collectWord({tag, "_cnt"}, c, 1'b0);
        collectWord({tag, "_sum"}, s, 1'b0);
        collectWord({tag, "_min"}, mn, 1'b0);
        collectWord({tag, "_max"}, mx, 1'b1);
    endtask

    initial begin
        int w;
        int w2;
        int idx;
        bit readyPat[7] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1};
        logic [31:0] toggleExp[4] = '{32'd2, 32'd150, 32'd50, 32'd100};

        RST_N         = 1'b0;
        S_AXIS_TDATA  = '0;
        S_AXIS_TSTRB  = '0;
        S_AXIS_TKEEP  = 1'b0;
        S_AXIS_TLAST  = 1'b0;
        S_AXIS_TVALID = 1'b0;
        M_AXIS_TREADY = 1'b1;

        repeat (2) @(posedge CLK);
        #1;
        checkOutput("rst_s_ready", 32'(S_AXIS_TREADY), 32'd0);
        checkOutput("rst_m_valid", 32'(M_AXIS_TVALID), 32'd0);
        checkOutput("rst_m_data", M_AXIS_TDATA, 32'd0);
        checkOutput("rst_m_last", 32'(M_AXIS_TLAST), 32'd0);
        checkOutput("rst_m_strb", 32'(M_AXIS_TSTRB), 32'd0);
        @(negedge CLK);
        RST_N = 1'b1;
        #1;
        checkOutput("ready_before_edge", 32'(S_AXIS_TREADY), 32'd0);
        @(posedge CLK);
        #1;
        checkOutput("ready_after_reset", 32'(S_AXIS_TREADY), 32'd1);

        $display("[TB] basic packet 10,20,5,7");
        applyStimulus(32'd10, 4'hF, 1'b0, w);
        applyStimulus(32'd20, 4'hF, 1'b0, w);
        applyStimulus(32'd5,  4'hF, 1'b0, w);
        applyStimulus(32'd7,  4'hF, 1'b1, w);
        checkOutput("p1_latency", 32'(M_AXIS_TVALID), 32'd1);
        checkOutput("p1_ready_low", 32'(S_AXIS_TREADY), 32'd0);
        collectResult("p1", 32'd4, 32'd42, 32'd5, 32'd20);

        $display("[TB] sum wraparound");
        applyStimulus(32'hFFFF_FFFF, 4'hF, 1'b0, w);
        applyStimulus(32'h0000_0002, 4'hF, 1'b1, w);
        collectResult("wrap", 32'd2, 32'h0000_0001, 32'h0000_0002, 32'hFFFF_FFFF);

        $display("[TB] strobe masking and null TLAST beat");
        applyStimulus(32'h1122_3344, 4'b0011, 1'b0, w);
        applyStimulus(32'hAABB_CCDD, 4'b0000, 1'b1, w);
        collectResult("mask", 32'd1, 32'h0000_3344, 32'h0000_3344, 32'h0000_3344);

        $display("[TB] empty packet");
        applyStimulus(32'h0000_0055, 4'b0000, 1'b1, w);
        collectResult("empty", 32'd0, 32'd0, 32'hFFFF_FFFF, 32'd0);

        $display("[TB] output backpressure");
        applyStimulus(32'd100, 4'hF, 1'b0, w);
        applyStimulus(32'd50,  4'hF, 1'b1, w);
        idx = 0;
        for (int i = 0; i < 7; i++) begin
            M_AXIS_TREADY = readyPat[i];
            @(negedge CLK);
            checkOutput("bp_valid", 32'(M_AXIS_TVALID), 32'd1);
            checkOutput("bp_data", M_AXIS_TDATA, toggleExp[idx]);
            checkOutput("bp_last", 32'(M_AXIS_TLAST), 32'(idx == 3));
            checkOutput("bp_s_ready", 32'(S_AXIS_TREADY), 32'd0);
            @(posedge CLK);
            #1;
            if (readyPat[i]) idx++;
        end
        M_AXIS_TREADY = 1'b1;
        @(negedge CLK);
        checkOutput("bp_done_valid", 32'(M_AXIS_TVALID), 32'd0);
        checkOutput("bp_done_ready", 32'(S_AXIS_TREADY), 32'd1);
        @(posedge CLK);
        #1;

        $display("[TB] reset mid-packet");
        applyStimulus(32'd100, 4'hF, 1'b0, w);
        applyStimulus(32'd200, 4'hF, 1'b0, w);
        @(negedge CLK);
        RST_N = 1'b0;
        #2;
        checkOutput("midrst_ready", 32'(S_AXIS_TREADY), 32'd0);
        checkOutput("midrst_valid", 32'(M_AXIS_TVALID), 32'd0);
        @(posedge CLK);
        @(negedge CLK);
        RST_N = 1'b1;
        @(posedge CLK);
        #1;
        applyStimulus(32'd3, 4'hF, 1'b0, w);
        applyStimulus(32'd3, 4'hF, 1'b1, w);
        collectResult("fresh", 32'd2, 32'd6, 32'd3, 32'd3);

        $display("[TB] back-to-back single-beat packets");
        applyStimulus(32'd9, 4'hF, 1'b1, w);
        fork
            collectResult("b2b_a", 32'd1, 32'd9, 32'd9, 32'd9);
            applyStimulus(32'd4, 4'hF, 1'b1, w2);
        join
        checkOutput("b2b_wait", 32'(w2), 32'd4);
        collectResult("b2b_b", 32'd1, 32'd4, 32'd4, 32'd4);

        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule
